// File: rtl/arb_requester_pkg.sv
// Shared types and default sizing for the arbiter requester block.
package arb_requester_pkg;

    localparam int LEN_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 255;
    // Wide enough for the largest legal TIMEOUT (1023)
    localparam int WAIT_W      = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_REL  = 2'd3
    } state_e;

endpackage

// File: rtl/arb_requester_if.sv
// Command and arbiter bus signals of one requester; master is the requester side.
interface arb_requester_if
    import arb_requester_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
);

    logic             cmd_valid;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_ready;
    logic             req;
    logic             gnt;
    logic             beat_valid;
    logic [LEN_W-1:0] beat_cnt;
    logic             done;
    logic             timeout;
    logic             busy;

    modport master (
        input  cmd_valid, cmd_len, gnt,
        output cmd_ready, req, beat_valid, beat_cnt, done, timeout, busy
    );

    modport slave (
        output cmd_valid, cmd_len, gnt,
        input  cmd_ready, req, beat_valid, beat_cnt, done, timeout, busy
    );

endinterface

// File: rtl/arb_requester_req_timer.sv
// Saturating count of ungranted request cycles; expired_o flags the edge that reaches TIMEOUT.
module req_timer
    import arb_requester_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic nreset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + WAIT_W'(1);
        end
    end

    // Look-ahead so the FSM can register its abort on the same edge the count lands
    assign expired_o = en_i && (count_d == LIMIT);

endmodule

// File: rtl/arb_requester.sv
// Burst requester: asks the arbiter for the bus, drives len+1 beats, releases for one cycle.
module arb_requester
    import arb_requester_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 nreset,
    arb_requester_if.master      bus
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             req_q, req_d;
    logic             beat_valid_q, beat_valid_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    logic             timer_clr;
    logic             timer_en;
    logic             wait_expired;
    logic             last_beat;

    assign last_beat = (beat_cnt_q == len_q);
    assign timer_en  = (state_q == ST_REQ) && !bus.gnt;
    assign timer_clr = ((state_q == ST_IDLE) && bus.cmd_valid) ||
                       ((state_q == ST_XFER) && !bus.gnt);

    req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_req_timer (
        .clk       (clk),
        .nreset    (nreset),
        .clear_i   (timer_clr),
        .en_i      (timer_en),
        .expired_o (wait_expired)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            req_q        <= 1'b0;
            beat_valid_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            req_q        <= req_d;
            beat_valid_q <= beat_valid_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.cmd_valid) state_d = ST_REQ;
            ST_REQ: begin
                if (bus.gnt)           state_d = ST_XFER;
                else if (wait_expired) state_d = ST_IDLE;
            end
            ST_XFER: begin
                if (!bus.gnt)      state_d = ST_REQ;
                else if (last_beat) state_d = ST_REL;
            end
            ST_REL:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        req_d        = req_q;
        beat_valid_d = beat_valid_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    len_d      = bus.cmd_len;
                    beat_cnt_d = '0;
                    req_d      = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.gnt) begin
                    beat_valid_d = 1'b1;
                end else if (wait_expired) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    len_d     = '0;
                end
            end
            ST_XFER: begin
                // Preemption: the beat in flight is not counted and is re-driven after regrant
                if (!bus.gnt) begin
                    beat_valid_d = 1'b0;
                end else if (last_beat) begin
                    beat_valid_d = 1'b0;
                    req_d        = 1'b0;
                    done_d       = 1'b1;
                end else begin
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                end
            end
            ST_REL: begin
                req_d = 1'b0;
            end
            default: begin
                req_d        = 1'b0;
                beat_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.req        = req_q;
    assign bus.beat_valid = beat_valid_q;
    assign bus.beat_cnt   = beat_cnt_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: single instance with TIMEOUT=5 plus a pair sharing a two-port arbiter.
module tb_arb_requester;
    import arb_requester_pkg::*;

    localparam int LW = 4;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    int vec = 0;
    int err = 0;

    arb_requester_if #(.LEN_W(LW)) bus ();
    arb_requester_if #(.LEN_W(LW)) bus_a ();
    arb_requester_if #(.LEN_W(LW)) bus_b ();

    arb_requester #(.LEN_W(LW), .TIMEOUT(5)) dut (.clk(clk), .nreset(nreset), .bus(bus));
    arb_requester #(.LEN_W(LW)) dut_a (.clk(clk), .nreset(nreset), .bus(bus_a));
    arb_requester #(.LEN_W(LW)) dut_b (.clk(clk), .nreset(nreset), .bus(bus_b));

    // Two-port arbiter: the last owner keeps the bus while both request
    logic owner_q;
    assign bus_a.gnt = bus_a.req && (!bus_b.req || !owner_q);
    assign bus_b.gnt = bus_b.req && (!bus_a.req || owner_q);
    always @(posedge clk or negedge nreset) begin
        if (!nreset)        owner_q <= 1'b0;
        else if (bus_b.gnt) owner_q <= 1'b1;
        else if (bus_a.gnt) owner_q <= 1'b0;
    end

    // Observed vector: req, beat_valid, done, timeout, cmd_ready, busy, beat_cnt
    logic [9:0] st;
    assign st = {bus.req, bus.beat_valid, bus.done, bus.timeout, bus.cmd_ready, bus.busy, bus.beat_cnt};

    function automatic logic [9:0] pk(input logic r, input logic bv, input logic dn,
                                      input logic to, input logic rdy, input logic bsy,
                                      input logic [3:0] c);
        return {r, bv, dn, to, rdy, bsy, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        bus.cmd_valid = 0; bus.cmd_len = '0; bus.gnt = 0;
        bus_a.cmd_valid = 0; bus_a.cmd_len = '0;
        bus_b.cmd_valid = 0; bus_b.cmd_len = '0;
        nreset = 0;
        #12;
        exp = pk(0, 0, 0, 0, 1, 0, 4'd0);
        vec++;
        if (st !== exp) begin
            err++; $display("FAIL reset_state: got %b want %b", st, exp);
        end
        @(negedge clk);
        nreset = 1;
    endtask

    task automatic test_burst4();
        logic [9:0] exp;
        bus.cmd_valid = 1; bus.cmd_len = 4'd3; bus.gnt = 0;
        tick();
        bus.cmd_valid = 0;
        exp = pk(1, 0, 0, 0, 0, 1, 4'd0);
        vec++;
        if (st !== exp) begin err++; $display("FAIL burst4_accept: got %b want %b", st, exp); end
        bus.gnt = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = pk(1, 1, 0, 0, 0, 1, i[3:0]);
            vec++;
            if (st !== exp) begin err++; $display("FAIL burst4_beat%0d: got %b want %b", i, st, exp); end
        end
        tick();
        exp = pk(0, 0, 1, 0, 0, 1, 4'd3);
        vec++;
        if (st !== exp) begin err++; $display("FAIL burst4_rel: got %b want %b", st, exp); end
        bus.gnt = 0;
        tick();
        exp = pk(0, 0, 0, 0, 1, 0, 4'd3);
        vec++;
        if (st !== exp) begin err++; $display("FAIL burst4_idle: got %b want %b", st, exp); end
    endtask

    task automatic test_single();
        logic [9:0] exp;
        bus.cmd_valid = 1; bus.cmd_len = 4'd0; bus.gnt = 1;
        tick();
        bus.cmd_valid = 0;
        exp = pk(1, 0, 0, 0, 0, 1, 4'd0);
        vec++;
        if (st !== exp) begin err++; $display("FAIL single_accept: got %b want %b", st, exp); end
        tick();
        exp = pk(1, 1, 0, 0, 0, 1, 4'd0);
        vec++;
        if (st !== exp) begin err++; $display("FAIL single_beat: got %b want %b", st, exp); end
        tick();
        exp = pk(0, 0, 1, 0, 0, 1, 4'd0);
        vec++;
        if (st !== exp) begin err++; $display("FAIL single_done: got %b want %b", st, exp); end
        bus.gnt = 0;
        tick();
        exp = pk(0, 0, 0, 0, 1, 0, 4'd0);
        vec++;
        if (st !== exp) begin err++; $display("FAIL single_idle: got %b want %b", st, exp); end
    endtask

    task automatic test_preempt();
        logic       gseq [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 0};
        logic [9:0] eseq [9];
        logic [9:0] exp;
        int beats = 0;
        int dones = 0;
        eseq[0] = pk(1, 1, 0, 0, 0, 1, 4'd0);
        eseq[1] = pk(1, 1, 0, 0, 0, 1, 4'd1);
        eseq[2] = pk(1, 0, 0, 0, 0, 1, 4'd1);
        eseq[3] = pk(1, 0, 0, 0, 0, 1, 4'd1);
        eseq[4] = pk(1, 0, 0, 0, 0, 1, 4'd1);
        eseq[5] = pk(1, 1, 0, 0, 0, 1, 4'd1);
        eseq[6] = pk(1, 1, 0, 0, 0, 1, 4'd2);
        eseq[7] = pk(0, 0, 1, 0, 0, 1, 4'd2);
        eseq[8] = pk(0, 0, 0, 0, 1, 0, 4'd2);
        bus.cmd_valid = 1; bus.cmd_len = 4'd2; bus.gnt = 0;
        tick();
        bus.cmd_valid = 0;
        for (int k = 0; k < 9; k++) begin
            bus.gnt = gseq[k];
            tick();
            exp = eseq[k];
            vec++;
            if (st !== exp) begin err++; $display("FAIL preempt_cyc%0d: got %b want %b", k, st, exp); end
            if (bus.done) dones++;
            if (bus.beat_valid && (k < 8) && gseq[k+1]) beats++;
        end
        bus.gnt = 0;
        vec++;
        if (beats != 3) begin err++; $display("FAIL preempt_beats: got %0d want 3", beats); end
        vec++;
        if (dones != 1) begin err++; $display("FAIL preempt_dones: got %0d want 1", dones); end
    endtask

    task automatic test_timeout();
        logic [9:0] exp;
        bus.cmd_valid = 1; bus.cmd_len = 4'd1; bus.gnt = 0;
        tick();
        bus.cmd_valid = 0;
        exp = pk(1, 0, 0, 0, 0, 1, 4'd0);
        vec++;
        if (st !== exp) begin err++; $display("FAIL timeout_accept: got %b want %b", st, exp); end
        for (int k = 1; k < 5; k++) begin
            tick();
            vec++;
            if (st !== exp) begin err++; $display("FAIL timeout_wait%0d: got %b want %b", k, st, exp); end
        end
        tick();
        exp = pk(0, 0, 0, 1, 1, 0, 4'd0);
        vec++;
        if (st !== exp) begin err++; $display("FAIL timeout_pulse: got %b want %b", st, exp); end
        tick();
        exp = pk(0, 0, 0, 0, 1, 0, 4'd0);
        vec++;
        if (st !== exp) begin err++; $display("FAIL timeout_after: got %b want %b", st, exp); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp;
        bus.cmd_valid = 1; bus.cmd_len = 4'd7; bus.gnt = 1;
        tick();
        bus.cmd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = pk(1, 1, 0, 0, 0, 1, i[3:0]);
            vec++;
            if (st !== exp) begin err++; $display("FAIL rstmid_beat%0d: got %b want %b", i, st, exp); end
        end
        #2;
        nreset = 0;
        #1;
        exp = pk(0, 0, 0, 0, 1, 0, 4'd0);
        vec++;
        if (st !== exp) begin err++; $display("FAIL rstmid_async: got %b want %b", st, exp); end
        tick();
        vec++;
        if (st !== exp) begin err++; $display("FAIL rstmid_held: got %b want %b", st, exp); end
        @(negedge clk);
        nreset = 1;
        bus.cmd_valid = 1; bus.cmd_len = 4'd1; bus.gnt = 1;
        tick();
        bus.cmd_valid = 0;
        exp = pk(1, 0, 0, 0, 0, 1, 4'd0);
        vec++;
        if (st !== exp) begin err++; $display("FAIL rstmid_first_cmd: got %b want %b", st, exp); end
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = pk(1, 1, 0, 0, 0, 1, i[3:0]);
            vec++;
            if (st !== exp) begin err++; $display("FAIL rstmid_new_beat%0d: got %b want %b", i, st, exp); end
        end
        tick();
        exp = pk(0, 0, 1, 0, 0, 1, 4'd1);
        vec++;
        if (st !== exp) begin err++; $display("FAIL rstmid_done: got %b want %b", st, exp); end
        bus.gnt = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        bus.cmd_valid = 1; bus.cmd_len = 4'd1; bus.gnt = 1;
        tick();
        bus.cmd_len = 4'd5;
        exp = pk(1, 0, 0, 0, 0, 1, 4'd0);
        vec++;
        if (st !== exp) begin err++; $display("FAIL b2b_accept: got %b want %b", st, exp); end
        tick();
        tick();
        exp = pk(1, 1, 0, 0, 0, 1, 4'd1);
        vec++;
        if (st !== exp) begin err++; $display("FAIL b2b_last_beat: got %b want %b", st, exp); end
        tick();
        exp = pk(0, 0, 1, 0, 0, 1, 4'd1);
        vec++;
        if (st !== exp) begin err++; $display("FAIL b2b_done1: got %b want %b", st, exp); end
        tick();
        exp = pk(0, 0, 0, 0, 1, 0, 4'd1);
        vec++;
        if (st !== exp) begin err++; $display("FAIL b2b_idle_gap: got %b want %b", st, exp); end
        tick();
        bus.cmd_valid = 0;
        exp = pk(1, 0, 0, 0, 0, 1, 4'd0);
        vec++;
        if (st !== exp) begin err++; $display("FAIL b2b_accept2: got %b want %b", st, exp); end
        for (int i = 0; i < 6; i++) tick();
        exp = pk(1, 1, 0, 0, 0, 1, 4'd5);
        vec++;
        if (st !== exp) begin err++; $display("FAIL b2b_beat5: got %b want %b", st, exp); end
        tick();
        exp = pk(0, 0, 1, 0, 0, 1, 4'd5);
        vec++;
        if (st !== exp) begin err++; $display("FAIL b2b_done2: got %b want %b", st, exp); end
        bus.gnt = 0;
        tick();
    endtask

    task automatic test_dual();
        int done_a = 0, done_b = 0, beats_a = 0, beats_b = 0;
        int cyc_a = -1, cyc_b = -1;
        bus_a.cmd_valid = 1; bus_a.cmd_len = 4'd1;
        bus_b.cmd_valid = 1; bus_b.cmd_len = 4'd1;
        tick();
        bus_a.cmd_valid = 0; bus_b.cmd_valid = 0;
        vec++;
        if (!(bus_a.req && bus_b.req)) begin
            err++; $display("FAIL dual_both_req: got a=%b b=%b want 1 1", bus_a.req, bus_b.req);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            vec++;
            if (bus_a.gnt && bus_b.gnt) begin err++; $display("FAIL dual_double_gnt cyc%0d: got both granted want one", k); end
            if (bus_a.beat_valid && bus_a.gnt) beats_a++;
            if (bus_b.beat_valid && bus_b.gnt) beats_b++;
            if (bus_a.done) begin done_a++; cyc_a = k; end
            if (bus_b.done) begin done_b++; cyc_b = k; end
        end
        vec++;
        if (done_a != 1 || done_b != 1) begin err++; $display("FAIL dual_dones: got a=%0d b=%0d want 1 1", done_a, done_b); end
        vec++;
        if (beats_a != 2 || beats_b != 2) begin err++; $display("FAIL dual_beats: got a=%0d b=%0d want 2 2", beats_a, beats_b); end
        vec++;
        if (cyc_a != 2 || cyc_b != 5) begin err++; $display("FAIL dual_order: got a@%0d b@%0d want a@2 b@5", cyc_a, cyc_b); end
        vec++;
        if (!(bus_a.cmd_ready && bus_b.cmd_ready)) begin
            err++; $display("FAIL dual_idle: got a=%b b=%b want 1 1", bus_a.cmd_ready, bus_b.cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_burst4();
        test_single();
        test_preempt();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_dual();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
